// File: rtl/s_muldiv_pkg.sv
// Shared encodings for the sequential multiply/divide unit: operation codes,
// FSM states and the op-field decoder.
package s_muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULU = 2'b00,
    MD_MULS = 2'b01,
    MD_DIVU = 2'b10
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } md_state_e;

  // The spare encoding 2'b11 behaves as an unsigned multiply.
  function automatic md_op_e decode_op(input logic [1:0] op);
    case (op)
      2'b01:   return MD_MULS;
      2'b10:   return MD_DIVU;
      default: return MD_MULU;
    endcase
  endfunction

endpackage

// File: rtl/s_muldiv_unit.sv
// Iterative WIDTH-cycle multiplier (unsigned/signed) and restoring divider
// sharing one hi/lo shift register pair, with a clock-enabled IDLE/RUN/DONE FSM.
module s_muldiv_unit
  import s_muldiv_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_en,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in_hi,
  input  logic [WIDTH-1:0] in_lo,
  input  logic [WIDTH-1:0] in_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_v
);

  localparam int CW = $clog2(WIDTH);

  md_state_e        r_state;
  md_op_e           r_op;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_neg;
  logic             r_ovf;
  logic [WIDTH-1:0] r_res_hi;
  logic [WIDTH-1:0] r_res_lo;
  logic             r_n;
  logic             r_z;
  logic             r_v;

  md_op_e             w_op;
  logic               w_launch;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shl;
  logic [WIDTH:0]     w_diff;
  logic               w_ge;
  logic [WIDTH-1:0]   w_nxt_hi;
  logic [WIDTH-1:0]   w_nxt_lo;
  logic [2*WIDTH-1:0] w_fin;
  logic               w_fn;
  logic               w_fz;
  logic               w_fv;

  function automatic logic [2*WIDTH-1:0] negate2w(input logic [2*WIDTH-1:0] x);
    return ~x + (2*WIDTH)'(1);
  endfunction

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? (~x + WIDTH'(1)) : x;
  endfunction

  // Operand conditioning at launch: signed multiply works on magnitudes.
  assign w_op     = decode_op(op);
  assign w_launch = start && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_a_mag  = magnitude(in_lo, w_op == MD_MULS);
  assign w_b_mag  = magnitude(in_b,  w_op == MD_MULS);

  // One iteration: shift-add for MUL, shift-compare-subtract for DIV.
  always_comb begin
    w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
    w_shl    = {r_hi, r_lo[WIDTH-1]};
    w_ge     = (w_shl >= {1'b0, r_b});
    w_diff   = w_shl - {1'b0, r_b};
    w_nxt_hi = r_hi;
    w_nxt_lo = r_lo;
    if (r_op == MD_DIVU) begin
      if (!r_ovf) begin
        w_nxt_hi = w_ge ? w_diff[WIDTH-1:0] : w_shl[WIDTH-1:0];
        w_nxt_lo = {r_lo[WIDTH-2:0], w_ge};
      end
    end else begin
      w_nxt_hi = w_sum[WIDTH:1];
      w_nxt_lo = {w_sum[0], r_lo[WIDTH-1:1]};
    end
  end

  // Final result and flags, captured on the RUN->DONE edge.
  always_comb begin
    w_fin = {w_nxt_hi, w_nxt_lo};
    if (r_op == MD_MULS && r_neg)
      w_fin = negate2w({w_nxt_hi, w_nxt_lo});
    else if (r_op == MD_DIVU && r_ovf)
      w_fin = {r_lo, {WIDTH{1'b1}}};
    if (r_op == MD_DIVU) begin
      w_fn = w_fin[WIDTH-1];
      w_fz = (w_fin[WIDTH-1:0] == '0);
      w_fv = r_ovf;
    end else begin
      w_fn = w_fin[2*WIDTH-1];
      w_fz = (w_fin[2*WIDTH-1:WIDTH] == '0);
      w_fv = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_op     <= MD_MULU;
      r_cnt    <= '0;
      r_b      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_neg    <= 1'b0;
      r_ovf    <= 1'b0;
      r_res_hi <= '0;
      r_res_lo <= '0;
      r_n      <= 1'b0;
      r_z      <= 1'b0;
      r_v      <= 1'b0;
    end else if (cpu_en) begin
      if (w_launch) begin
        r_state <= ST_RUN;
        r_op    <= w_op;
        r_cnt   <= CW'(WIDTH - 1);
        r_neg   <= (w_op == MD_MULS) && (in_lo[WIDTH-1] ^ in_b[WIDTH-1]);
        r_ovf   <= (w_op == MD_DIVU) && (in_hi >= in_b);
        if (w_op == MD_DIVU) begin
          r_hi <= in_hi;
          r_lo <= in_lo;
          r_b  <= in_b;
        end else begin
          r_hi <= '0;
          r_lo <= w_a_mag;
          r_b  <= w_b_mag;
        end
      end else if (r_state == ST_RUN) begin
        r_hi  <= w_nxt_hi;
        r_lo  <= w_nxt_lo;
        r_cnt <= r_cnt - CW'(1);
        if (r_cnt == '0) begin
          r_state  <= ST_DONE;
          r_res_hi <= w_fin[2*WIDTH-1:WIDTH];
          r_res_lo <= w_fin[WIDTH-1:0];
          r_n      <= w_fn;
          r_z      <= w_fz;
          r_v      <= w_fv;
        end
      end else begin
        r_state <= ST_IDLE;
      end
    end
  end

  assign busy   = (r_state == ST_RUN);
  assign done   = (r_state == ST_DONE);
  assign res_hi = r_res_hi;
  assign res_lo = r_res_lo;
  assign flag_n = r_n;
  assign flag_z = r_z;
  assign flag_v = r_v;

endmodule

// File: tb/tb_s_muldiv_unit.sv
// Scoreboard bench for s_muldiv_unit at WIDTH=8: expected results come from a
// behavioural model using the language's own * / % operators.
module tb_s_muldiv_unit;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         n;
    logic         z;
    logic         v;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         cpu_en;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] in_hi;
  logic [W-1:0] in_lo;
  logic [W-1:0] in_b;
  logic         busy;
  logic         done;
  logic [W-1:0] res_hi;
  logic [W-1:0] res_lo;
  logic         flag_n;
  logic         flag_z;
  logic         flag_v;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  s_muldiv_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .cpu_en (cpu_en),
    .start  (start),
    .op     (op),
    .in_hi  (in_hi),
    .in_lo  (in_lo),
    .in_b   (in_b),
    .busy   (busy),
    .done   (done),
    .res_hi (res_hi),
    .res_lo (res_lo),
    .flag_n (flag_n),
    .flag_z (flag_z),
    .flag_v (flag_v)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] h,
                                 input logic [W-1:0] l, input logic [W-1:0] b);
    exp_t                    e;
    logic [2*W-1:0]          p;
    logic signed [2*W-1:0]   sp;
    logic [2*W-1:0]          dvd;
    if (o == 2'b10) begin
      if (h >= b) begin
        e.hi = l;
        e.lo = '1;
        e.v  = 1'b1;
      end else begin
        dvd  = {h, l};
        e.lo = W'(dvd / {{W{1'b0}}, b});
        e.hi = W'(dvd % {{W{1'b0}}, b});
        e.v  = 1'b0;
      end
      e.n = e.lo[W-1];
      e.z = (e.lo == '0);
    end else begin
      if (o == 2'b01) begin
        sp = $signed(l) * $signed(b);
        p  = sp;
      end else begin
        p = {{W{1'b0}}, l} * {{W{1'b0}}, b};
      end
      e.hi = p[2*W-1:W];
      e.lo = p[W-1:0];
      e.n  = e.hi[W-1];
      e.z  = (e.hi == '0);
      e.v  = 1'b0;
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one start edge and records the expected result.
  task automatic launch(input logic [1:0] o, input logic [W-1:0] h,
                        input logic [W-1:0] l, input logic [W-1:0] b);
    sb_q.push_back(model(o, h, l, b));
    op = o; in_hi = h; in_lo = l; in_b = b;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Counts enabled edges from the start edge (inclusive) until done is seen.
  task automatic wait_done(output int lat);
    lat = 1;
    while (done !== 1'b1 && lat < 200) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    exp_t got;
    reset = 1'b1; cpu_en = 1'b0; start = 1'b1;
    op = 2'b00; in_hi = 8'h11; in_lo = 8'h22; in_b = 8'h33;
    step();
    step();
    got = {res_hi, res_lo, flag_n, flag_z, flag_v};
    n_checks++;
    if ({busy, done} !== 2'b00 || got !== '0) begin
      n_errors++;
      $display("FAIL reset_state: busy=%b done=%b out=%h, required busy=0 done=0 out=0", busy, done, got);
    end
    reset = 1'b0; start = 1'b0; cpu_en = 1'b1;
    step();
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL idle_after_reset: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_mulu();
    int   lat;
    exp_t got, exp;
    launch(2'b00, 8'h00, 8'h12, 8'h34);
    n_checks++;
    if ({busy, done} !== 2'b10) begin
      n_errors++;
      $display("FAIL mulu_busy: busy=%b done=%b, required busy=1 done=0", busy, done);
    end
    wait_done(lat);
    n_checks++;
    if (lat != W + 1 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL mulu_latency: latency=%0d busy=%b, required %0d and busy=0", lat, busy, W + 1);
    end
    exp = sb_q.pop_front();
    got = {res_hi, res_lo, flag_n, flag_z, flag_v};
    n_checks++;
    if (got !== exp || exp !== {8'h03, 8'hA8, 3'b000}) begin
      n_errors++;
      $display("FAIL mulu_result: got %h, required %h", got, exp);
    end
  endtask

  // Table of directed cases covering signed, division and overflow corners.
  task automatic test_ops();
    logic [1:0]   t_op[8] = '{2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b11, 2'b10, 2'b00};
    logic [W-1:0] t_hi[8] = '{8'h00, 8'h12, 8'h01, 8'h00, 8'h00, 8'hAA, 8'h05, 8'h00};
    logic [W-1:0] t_lo[8] = '{8'hFF, 8'h34, 8'h00, 8'h80, 8'h80, 8'hFF, 8'h77, 8'h00};
    logic [W-1:0] t_b [8] = '{8'h02, 8'h56, 8'h00, 8'h80, 8'h7F, 8'hFF, 8'h05, 8'h9C};
    int   lat;
    exp_t got, exp;
    for (int i = 0; i < 8; i++) begin
      launch(t_op[i], t_hi[i], t_lo[i], t_b[i]);
      wait_done(lat);
      exp = sb_q.pop_front();
      got = {res_hi, res_lo, flag_n, flag_z, flag_v};
      n_checks++;
      if (done !== 1'b1 || got !== exp) begin
        n_errors++;
        $display("FAIL op_case%0d: done=%b got %h, required done=1 %h", i, done, got, exp);
      end
    end
  endtask

  task automatic test_spec_values();
    int   lat;
    exp_t got;
    sb_q.push_back({8'hFF, 8'hFE, 3'b100});
    op = 2'b01; in_hi = 8'h00; in_lo = 8'hFF; in_b = 8'h02;
    start = 1'b1; step(); start = 1'b0;
    wait_done(lat);
    got = {res_hi, res_lo, flag_n, flag_z, flag_v};
    n_checks++;
    if (got !== sb_q.pop_front()) begin
      n_errors++;
      $display("FAIL muls_ff_x_02: got %h, required ff_fe n=1 z=0 v=0", got);
    end
    sb_q.push_back({8'h10, 8'h36, 3'b000});
    op = 2'b10; in_hi = 8'h12; in_lo = 8'h34; in_b = 8'h56;
    start = 1'b1; step(); start = 1'b0;
    wait_done(lat);
    got = {res_hi, res_lo, flag_n, flag_z, flag_v};
    n_checks++;
    if (got !== sb_q.pop_front()) begin
      n_errors++;
      $display("FAIL divu_1234_56: got %h, required 10_36 v=0", got);
    end
    sb_q.push_back({8'h00, 8'hFF, 3'b101});
    op = 2'b10; in_hi = 8'h01; in_lo = 8'h00; in_b = 8'h00;
    start = 1'b1; step(); start = 1'b0;
    wait_done(lat);
    got = {res_hi, res_lo, flag_n, flag_z, flag_v};
    n_checks++;
    if (got !== sb_q.pop_front() || lat != W + 1) begin
      n_errors++;
      $display("FAIL divu_by_zero: got %h lat=%0d, required 00_ff n=1 v=1 lat=%0d", got, lat, W + 1);
    end
  endtask

  task automatic test_cpu_en();
    int   lat;
    exp_t got, exp;
    logic stuck;
    launch(2'b00, 8'h00, 8'h12, 8'h34);
    lat = 1;
    step(); lat++;
    step(); lat++;
    cpu_en = 1'b0;
    stuck = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); lat++;
      if (busy !== 1'b1) stuck = 1'b1;
    end
    n_checks++;
    if (stuck) begin
      n_errors++;
      $display("FAIL cpu_en_freeze_busy: busy dropped while disabled, required 1");
    end
    cpu_en = 1'b1;
    op = 2'b10; in_hi = 8'h00; in_lo = 8'hFF; in_b = 8'h01;
    start = 1'b1;
    step(); lat++;
    start = 1'b0;
    while (done !== 1'b1 && lat < 200) begin
      step();
      lat++;
    end
    n_checks++;
    if (lat != W + 1 + 3) begin
      n_errors++;
      $display("FAIL cpu_en_latency: %0d clocks, required %0d", lat, W + 4);
    end
    exp = sb_q.pop_front();
    got = {res_hi, res_lo, flag_n, flag_z, flag_v};
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL cpu_en_result: got %h, required %h", got, exp);
    end
    cpu_en = 1'b0;
    step();
    step();
    n_checks++;
    if (done !== 1'b1 || {res_hi, res_lo} !== {exp.hi, exp.lo}) begin
      n_errors++;
      $display("FAIL done_held: done=%b res=%h, required done=1 res=%h", done, {res_hi, res_lo}, {exp.hi, exp.lo});
    end
    cpu_en = 1'b1;
    step();
    n_checks++;
    if ({busy, done} !== 2'b00 || {res_hi, res_lo} !== {exp.hi, exp.lo}) begin
      n_errors++;
      $display("FAIL done_to_idle: busy=%b done=%b res=%h, required 0 0 %h", busy, done, {res_hi, res_lo}, {exp.hi, exp.lo});
    end
  endtask

  task automatic test_reset_abort();
    int   lat;
    exp_t got, exp;
    logic seen;
    launch(2'b01, 8'h00, 8'h80, 8'h7F);
    void'(sb_q.pop_back());
    step();
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    got = {res_hi, res_lo, flag_n, flag_z, flag_v};
    n_checks++;
    if ({busy, done} !== 2'b00 || got !== '0) begin
      n_errors++;
      $display("FAIL reset_abort_state: busy=%b done=%b out=%h, required 0 0 0", busy, done, got);
    end
    seen = 1'b0;
    for (int i = 0; i < W + 3; i++) begin
      step();
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_errors++;
      $display("FAIL reset_abort_nodone: activity after abort, required none");
    end
    launch(2'b10, 8'h05, 8'h77, 8'h09);
    wait_done(lat);
    exp = sb_q.pop_front();
    got = {res_hi, res_lo, flag_n, flag_z, flag_v};
    n_checks++;
    if (got !== exp || lat != W + 1) begin
      n_errors++;
      $display("FAIL reset_abort_restart: got %h lat=%0d, required %h lat=%0d", got, lat, exp, W + 1);
    end
  endtask

  task automatic test_back_to_back();
    int   lat;
    int   gap;
    exp_t got, exp;
    launch(2'b01, 8'h00, 8'hC3, 8'h5A);
    wait_done(lat);
    exp = sb_q.pop_front();
    got = {res_hi, res_lo, flag_n, flag_z, flag_v};
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL b2b_first: got %h, required %h", got, exp);
    end
    sb_q.push_back(model(2'b10, 8'h3E, 8'h21, 8'hF1));
    op = 2'b10; in_hi = 8'h3E; in_lo = 8'h21; in_b = 8'hF1;
    start = 1'b1;
    step();
    start = 1'b0;
    n_checks++;
    if ({busy, done} !== 2'b10) begin
      n_errors++;
      $display("FAIL b2b_restart: busy=%b done=%b, required busy=1 done=0", busy, done);
    end
    gap = 1;
    while (done !== 1'b1 && gap < 200) begin
      step();
      if (done !== 1'b1) gap++;
    end
    n_checks++;
    if (gap != W || done !== 1'b1) begin
      n_errors++;
      $display("FAIL b2b_gap: %0d edges done=%b, required %0d and done=1", gap, done, W);
    end
    exp = sb_q.pop_front();
    got = {res_hi, res_lo, flag_n, flag_z, flag_v};
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL b2b_second: got %h, required %h", got, exp);
    end
    step();
  endtask

  task automatic test_random();
    int           lat;
    exp_t         got, exp;
    logic [1:0]   o;
    logic [W-1:0] h, l, b;
    for (int i = 0; i < 10; i++) begin
      o = 2'($urandom_range(0, 3));
      l = W'($urandom_range(0, 255));
      b = W'($urandom_range(1, 255));
      h = (i % 4 == 3) ? W'($urandom_range(0, 255)) : W'($urandom_range(0, int'(b) - 1));
      launch(o, h, l, b);
      wait_done(lat);
      exp = sb_q.pop_front();
      got = {res_hi, res_lo, flag_n, flag_z, flag_v};
      n_checks++;
      if (got !== exp || lat != W + 1) begin
        n_errors++;
        $display("FAIL random%0d op=%b %h_%h/%h: got %h lat=%0d, required %h lat=%0d",
                 i, o, h, l, b, got, lat, exp, W + 1);
      end
    end
  endtask

  initial begin
    reset = 1'b1; cpu_en = 1'b1; start = 1'b0;
    op = '0; in_hi = '0; in_lo = '0; in_b = '0;
    test_reset();
    test_mulu();
    test_spec_values();
    test_ops();
    test_cpu_en();
    test_reset_abort();
    test_back_to_back();
    test_random();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
